key_loader: RTL and testbench
=============================

KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 Parameter KEY_BYTES, default 4, SHALL set the number of key bytes per frame (key width = 8*KEY_BYTES).
REQ-002 Parameter MAX_FAIL, default 3, SHALL set the number of consecutive bad frames that forces lockout.
REQ-003 Parameter CHK_SEED, default 8'hA5, SHALL be the seed XORed into the frame check byte.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream data.
REQ-008 in_ready  output  1  byte-stream ready; a byte is accepted when in_valid and in_ready are both high on a clock edge.
REQ-009 key_clear  input  1  one-cycle request to zeroize the key and re-arm loading.
REQ-010 key  output  8*KEY_BYTES  key vector driven to the locked core's keyinput bus; bit i maps to keyinput i.
REQ-011 key_valid  output  1  key holds a verified value.
REQ-012 err  output  1  one-cycle pulse on a bad check byte.
REQ-013 locked_out  output  1  lockout reached; only reset clears it.
REQ-014 fail_cnt  output  2  consecutive-failure count, saturating at MAX_FAIL.

Function
REQ-015 A frame SHALL be KEY_BYTES key bytes followed by one check byte; byte k SHALL fill shadow[8k+7:8k], so byte 0 lands in key bits 7:0.
REQ-016 The expected check byte SHALL be CHK_SEED XORed with every key byte of the frame.
REQ-017 The FSM SHALL have exactly four states: IDLE, LOAD, ARMED, LOCKOUT.
REQ-018 IDLE: in_ready=1; an accepted byte SHALL be stored as byte 0 and move the FSM to LOAD with byte index 1.
REQ-019 LOAD: in_ready=1; bytes SHALL be accepted into the shadow register until the index reaches KEY_BYTES, and the next accepted byte SHALL be taken as the check byte.
REQ-020 On a good check, in the acceptance cycle: shadow SHALL be copied to key, and fail_cnt cleared; key_valid SHALL rise on the next cycle and the FSM SHALL enter ARMED.
REQ-021 On a bad check: err SHALL pulse for exactly one cycle after acceptance, fail_cnt SHALL increment, shadow and index SHALL clear, and the FSM SHALL return to IDLE; if fail_cnt reaches MAX_FAIL, the FSM SHALL enter LOCKOUT instead.
REQ-022 ARMED: in_ready=0; key and key_valid SHALL hold until key_clear or reset.
REQ-023 LOCKOUT: in_ready=0, key=0, key_valid=0, locked_out=1; key_clear SHALL be ignored.
REQ-024 key_clear in IDLE, LOAD or ARMED SHALL zero key, shadow and index, deassert key_valid on the next cycle and go to IDLE; fail_cnt SHALL be unchanged.
REQ-025 If key_clear and a byte acceptance coincide, key_clear SHALL win and the byte SHALL be discarded.
REQ-026 key SHALL read all-zero whenever key_valid is 0; partially loaded shadow bytes SHALL never reach key.
REQ-027 in_ready SHALL depend only on registered state, never combinationally on in_valid.
REQ-028 Stalls (in_valid low) SHALL be allowed anywhere mid-frame without any timeout.

Reset
REQ-029 With rst_n low at a clock edge: FSM=IDLE, index=0, shadow=0, key=0, key_valid=0, err=0, locked_out=0, fail_cnt=0.
REQ-030 Reset mid-frame or in LOCKOUT SHALL discard all partial data and restore the values in REQ-029.
REQ-031 in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-032 The state enum, CHK_SEED default and MAX_FAIL default SHALL live in a shared package, key_loader_pkg.
REQ-033 The check-byte accumulator SHALL be one sub-module, key_chk_acc (clear, accumulate-enable, 8-bit running XOR).

Verification
REQ-034 Bytes 11,22,33,44 then E1 (hex) -> key=32'h44332211, key_valid=1 one cycle after E1 is accepted, in_ready=0.
REQ-035 Same key bytes with check E0 -> err pulse of one cycle, fail_cnt=1, key=0, FSM in IDLE, in_ready=1.
REQ-036 Three consecutive bad frames -> locked_out=1, in_ready=0; a following key_clear and a good frame -> no change.
REQ-037 key_clear asserted while the third key byte is accepted -> byte discarded, FSM in IDLE; a full good frame afterward -> key_valid=1.
REQ-038 rst_n low for one cycle while ARMED with key 44332211 -> key=0, key_valid=0, fail_cnt=0, in_ready=1 on the next cycle.
REQ-039 Random in_valid gaps of 0-5 cycles inside a good frame -> same result as REQ-034, with no byte lost or duplicated.

Source files
------------

// File: rtl/key_loader_pkg.sv
// ---------------------------------------------------------------------------
// key_loader_pkg
// Shared definitions for the key loader: controller state encoding, default
// check seed and lockout threshold, and a saturating failure-count helper.
// ---------------------------------------------------------------------------
package key_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_ARMED   = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  localparam logic [7:0] CHK_SEED_DEF = 8'hA5;
  localparam int         MAX_FAIL_DEF = 3;

  // Increment a 2-bit failure count, pinning it at max_v.
  function automatic logic [1:0] sat_inc(input logic [1:0] cnt, input int max_v);
    if (int'(cnt) >= max_v) begin
      return 2'(max_v);
    end
    return cnt + 2'd1;
  endfunction

endpackage

// File: rtl/key_chk_acc.sv
// ---------------------------------------------------------------------------
// key_chk_acc
// Running XOR of the key bytes of the frame currently being loaded. The
// seed is applied by the caller at compare time, so a cleared accumulator
// always reads zero.
//
// Ports
//   clk     in   clock
//   rst_n   in   synchronous active-low reset
//   i_clr   in   zero the accumulator (has priority over i_en)
//   i_en    in   fold i_data into the accumulator
//   i_data  in   byte to fold in
//   o_acc   out  current running XOR
// ---------------------------------------------------------------------------
module key_chk_acc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_data,
  output logic [7:0] o_acc
);

  logic [7:0] r_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= 8'h00;
    end else if (i_clr) begin
      r_acc <= 8'h00;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_data;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/key_loader.sv
// ---------------------------------------------------------------------------
// key_loader
// Loads a key for a logic-locked core from a byte stream. A frame is
// KEY_BYTES key bytes (byte 0 first, landing in key[7:0]) followed by a
// check byte equal to CHK_SEED XOR all key bytes. A good frame publishes the
// key; MAX_FAIL bad frames in a row lock the loader out until reset.
//
// State table
//   state      | meaning
//   IDLE       | waiting for byte 0 of a frame, in_ready high
//   LOAD       | collecting key bytes, then the check byte
//   ARMED      | verified key driven on key, key_valid high, no input taken
//   LOCKOUT    | too many bad frames; key zero, only reset recovers
//
// Ports
//   clk         in   sole clock
//   rst_n       in   synchronous active-low reset
//   in_valid    in   byte-stream valid
//   in_data     in   byte-stream data
//   in_ready    out  byte-stream ready (registered)
//   key_clear   in   zeroize key and re-arm loading (ignored in LOCKOUT)
//   key         out  verified key, zero whenever key_valid is low
//   key_valid   out  key holds a verified value
//   err         out  one-cycle pulse after a bad check byte
//   locked_out  out  lockout reached
//   fail_cnt    out  consecutive bad frames, saturating at MAX_FAIL
// ---------------------------------------------------------------------------
module key_loader
  import key_loader_pkg::*;
#(
  parameter int         KEY_BYTES = 4,
  parameter int         MAX_FAIL  = MAX_FAIL_DEF,
  parameter logic [7:0] CHK_SEED  = CHK_SEED_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  input  logic                   key_clear,
  output logic [8*KEY_BYTES-1:0] key,
  output logic                   key_valid,
  output logic                   err,
  output logic                   locked_out,
  output logic [1:0]             fail_cnt
);

  localparam int IDX_W = $clog2(KEY_BYTES + 1);

  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [8*KEY_BYTES-1:0] r_shadow;
  logic [8*KEY_BYTES-1:0] r_key;
  logic                   r_key_valid;
  logic                   r_err;
  logic                   r_locked_out;
  logic [1:0]             r_fail_cnt;
  logic                   r_in_ready;

  logic       w_accept;
  logic       w_chk_byte;
  logic       w_acc_en;
  logic       w_acc_clr;
  logic [7:0] w_acc;
  logic       w_chk_ok;
  logic [1:0] w_fail_next;
  logic       w_lock;

  assign w_accept   = in_valid && r_in_ready;
  // Once the index has reached KEY_BYTES the next byte is the check byte.
  assign w_chk_byte = (r_state == ST_LOAD) && (r_idx == IDX_W'(KEY_BYTES));

  assign w_acc_en  = w_accept && !key_clear && !w_chk_byte;
  assign w_acc_clr = (key_clear && (r_state != ST_LOCKOUT)) ||
                     (w_accept && w_chk_byte);

  key_chk_acc u_chk_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_acc_clr),
    .i_en   (w_acc_en),
    .i_data (in_data),
    .o_acc  (w_acc)
  );

  assign w_chk_ok    = ((w_acc ^ CHK_SEED) == in_data);
  assign w_fail_next = sat_inc(r_fail_cnt, MAX_FAIL);
  assign w_lock      = (int'(w_fail_next) >= MAX_FAIL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_key        <= '0;
      r_key_valid  <= 1'b0;
      r_err        <= 1'b0;
      r_locked_out <= 1'b0;
      r_fail_cnt   <= 2'd0;
      r_in_ready   <= 1'b1;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (key_clear) begin
            r_shadow <= '0;
            r_idx    <= '0;
            r_key    <= '0;
          end else if (w_accept) begin
            r_shadow[7:0] <= in_data;
            r_idx         <= IDX_W'(1);
            r_state       <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (key_clear) begin
            // Clear beats a coincident byte; the byte is simply dropped.
            r_shadow <= '0;
            r_idx    <= '0;
            r_key    <= '0;
            r_state  <= ST_IDLE;
          end else if (w_accept) begin
            if (!w_chk_byte) begin
              for (int b = 1; b < KEY_BYTES; b++) begin
                if (r_idx == IDX_W'(b)) begin
                  r_shadow[8*b +: 8] <= in_data;
                end
              end
              r_idx <= r_idx + IDX_W'(1);
            end else if (w_chk_ok) begin
              r_key       <= r_shadow;
              r_key_valid <= 1'b1;
              r_fail_cnt  <= 2'd0;
              r_shadow    <= '0;
              r_idx       <= '0;
              r_in_ready  <= 1'b0;
              r_state     <= ST_ARMED;
            end else begin
              r_err      <= 1'b1;
              r_fail_cnt <= w_fail_next;
              r_shadow   <= '0;
              r_idx      <= '0;
              if (w_lock) begin
                r_locked_out <= 1'b1;
                r_in_ready   <= 1'b0;
                r_state      <= ST_LOCKOUT;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
        end

        ST_ARMED: begin
          if (key_clear) begin
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_shadow    <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        ST_LOCKOUT: begin
          // Sticky until reset; hold the zeroized outputs.
          r_key        <= '0;
          r_key_valid  <= 1'b0;
          r_in_ready   <= 1'b0;
          r_locked_out <= 1'b1;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign key        = r_key;
  assign key_valid  = r_key_valid;
  assign err        = r_err;
  assign locked_out = r_locked_out;
  assign fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_key_loader.sv
// ---------------------------------------------------------------------------
// tb_key_loader
// Self-checking bench for key_loader with default parameters. A frame-level
// reference model predicts the outputs after each frame, clear or reset.
// ---------------------------------------------------------------------------
module tb_key_loader;

  localparam int         KB   = 4;
  localparam logic [7:0] SEED = 8'hA5;
  localparam int         MAXF = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          key_clear;
  logic [8*KB-1:0] key;
  logic          key_valid;
  logic          err;
  logic          locked_out;
  logic [1:0]    fail_cnt;

  key_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .key_clear  (key_clear),
    .key        (key),
    .key_valid  (key_valid),
    .err        (err),
    .locked_out (locked_out),
    .fail_cnt   (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model (frame level)
  logic [8*KB-1:0] m_key;
  logic            m_valid;
  int              m_fail;
  logic            m_locked;
  logic            m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] good_chk(input logic [8*KB-1:0] kv);
    logic [7:0] x;
    x = SEED;
    for (int k = 0; k < KB; k++) x = x ^ kv[8*k +: 8];
    return x;
  endfunction

  task automatic model_reset();
    m_key = '0; m_valid = 1'b0; m_fail = 0; m_locked = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_frame(input logic [8*KB-1:0] kv, input logic [7:0] c);
    if (c == good_chk(kv)) begin
      m_key = kv; m_valid = 1'b1; m_fail = 0; m_err = 1'b0;
    end else begin
      m_fail   = (m_fail < MAXF) ? m_fail + 1 : MAXF;
      m_key    = '0;
      m_valid  = 1'b0;
      m_locked = (m_fail >= MAXF);
      m_err    = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".key"},       64'(key),        64'(m_key));
    chk({tag, ".key_valid"}, 64'(key_valid),  64'(m_valid));
    chk({tag, ".err"},       64'(err),        64'(m_err));
    chk({tag, ".fail_cnt"},  64'(fail_cnt),   64'(m_fail));
    chk({tag, ".locked"},    64'(locked_out), 64'(m_locked));
    chk({tag, ".in_ready"},  64'(in_ready),   64'(!m_valid && !m_locked));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic do_clear();
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    if (!m_locked) begin
      m_key = '0; m_valid = 1'b0;
    end
    m_err = 1'b0;
  endtask

  // Present one byte after 'gap' idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_frame(input logic [8*KB-1:0] kv, input logic [7:0] c,
                            input int max_gap, input string tag);
    for (int k = 0; k < KB; k++) send_byte(kv[8*k +: 8], $urandom_range(0, max_gap));
    chk({tag, ".partial_key"}, 64'(key), 64'd0);
    send_byte(c, $urandom_range(0, max_gap));
    model_frame(kv, c);
    check_state(tag);
    tick();
    m_err = 1'b0;
    chk({tag, ".err_after"}, 64'(err), 64'd0);
  endtask

  initial begin
    logic [8*KB-1:0] kv;
    logic [7:0]      c;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; key_clear = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    check_state("reset");

    // Directed good frame
    send_frame(32'h44332211, 8'hE1, 0, "good");

    // Clear from ARMED
    do_clear();
    check_state("clear_armed");

    // Directed bad frame
    send_frame(32'h44332211, 8'hE0, 0, "bad");

    // key_clear coincident with the third key byte
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    in_valid = 1'b1; in_data = 8'h33; key_clear = 1'b1;
    tick();
    in_valid = 1'b0; key_clear = 1'b0;
    check_state("clr_mid");
    send_frame(32'h44332211, 8'hE1, 2, "after_clr");

    // Reset while ARMED
    do_reset();
    check_state("rst_armed");

    // Lockout
    for (int i = 0; i < MAXF; i++) send_frame(32'($urandom), 8'h00 ^ 8'h5A, 1, "to_lock");
    // Force the last frames bad regardless of random keys
    while (!m_locked) begin
      kv = 32'($urandom);
      send_frame(kv, ~good_chk(kv), 1, "to_lock2");
    end
    check_state("locked");
    do_clear();
    for (int k = 0; k < KB + 1; k++) begin
      in_valid = 1'b1;
      in_data  = (k < KB) ? 8'(8'h11 * (k + 1)) : 8'hE1;
      tick();
    end
    in_valid = 1'b0;
    check_state("lock_hold");
    do_reset();
    check_state("lock_rst");

    // Randomized frames with gaps, clears and resets
    for (int it = 0; it < 30; it++) begin
      if (m_locked) begin
        do_reset();
        check_state("r_reset");
      end else if (m_valid) begin
        if ($urandom_range(0, 3) == 0) begin
          do_reset();
          check_state("r_reset");
        end else begin
          do_clear();
          check_state("r_clear");
        end
      end
      kv = 32'($urandom);
      c  = good_chk(kv);
      if ($urandom_range(0, 2) == 0) c = c ^ 8'($urandom_range(1, 255));
      send_frame(kv, c, 5, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
